// File: rtl/result_reader_pkg.sv
// Shared types and default widths for the result-memory read-back engine.
// Defaults match the 8x8 approximate multiplier datapath.
package result_reader_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/result_reader.sv
// Walks the multiplier result memory from address 0 and streams each
// product out on a valid/ready interface, one word per read.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              rd_done
);

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    clamp_c;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                rd_done_q, rd_done_d;

  // Controller: next state, word counter and registered strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_en_d     = 1'b0;
    rd_done_d   = 1'b0;
    busy_d      = 1'b0;
    clamp_c     = (num_words > DEPTH_C) ? DEPTH_C : num_words;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          limit_d = clamp_c;
          cnt_d   = '0;
          state_d = (clamp_c == '0) ? FIN : ADDR;
        end
      end
      ADDR: state_d = CAP;
      CAP: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == limit_q - CNT_W'(1)) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ADDR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    if (state_d == ADDR) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ADDR_W'(cnt_d);
    end
    rd_done_d = (state_d == FIN);
    busy_d    = (state_d != IDLE);
  end

  // State and output holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      limit_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: a sync-read memory model feeds the
// DUT, the stimulus pushes expected words, a negedge monitor pops and checks.
module tb_result_reader;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              rd_done;

  result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  int cyc = 0, n_addr = 0, n_done = 0, n_busy = 0, n_hs = 0, done_cyc = 0;
  int addr_log [256];
  int hs_cyc [64];
  logic ov_prev = 1'b0, or_prev = 1'b0, rst_prev = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: logs strobes, checks held words under backpressure, scores handshakes.
  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      if (n_addr < 256) addr_log[n_addr] = int'(rd_addr);
      n_addr++;
    end
    if (rd_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
    if (!rst && !rst_prev && ov_prev && !or_prev) begin
      check("hold_valid", int'(out_valid), 1);
      if (exp_q.size() > 0) check("hold_data", int'(out_data), int'(exp_q[0]));
    end
    if (out_valid && out_ready && !rst) begin
      if (n_hs < 64) hs_cyc[n_hs] = cyc;
      n_hs++;
      if (exp_q.size() == 0) check("unexpected_word", int'(out_data), -1);
      else check("word", int'(out_data), int'(exp_q.pop_front()));
    end
    ov_prev  = out_valid;
    or_prev  = out_ready;
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n);
    int lim;
    lim = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    for (int k = 0; k < lim; k++) exp_q.push_back(mem[k]);
  endtask

  task automatic pulse_start(input int n, output int sc);
    start     = 1'b1;
    num_words = (ADDR_W + 1)'(n);
    sc        = cyc + 1;
    step();
    start     = 1'b0;
  endtask

  // Returns at negedge+1 of the rd_done cycle, then confirms busy drops next cycle.
  task automatic wait_done(input string name, input int base);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (n_done > base) break;
    end
    if (t == 300) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
    #1;
    check({name, "_busy_after_done"}, int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    if (t == 50) check({name, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_hs(input int target);
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (n_hs >= target) break;
    end
    if (t == 100) check("hs_timeout", 0, 1);
  endtask

  initial begin
    int sc, d0, a0, h0, b0, dummy;
    rst = 1'b1; start = 1'b0; num_words = '0; out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'(16'h0100 + i);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_done", int'(rd_done), 0);
    step();

    // 1: four words, ready tied high
    out_ready = 1'b1;
    d0 = n_done; a0 = n_addr; h0 = n_hs;
    push_words(4);
    pulse_start(4, sc);
    wait_done("t1", d0);
    check("t1_first_valid_lat", hs_cyc[h0] - sc, 3);
    for (int i = 1; i < 4; i++) check("t1_hs_spacing", hs_cyc[h0+i] - hs_cyc[h0+i-1], 3);
    check("t1_done_after_last", done_cyc - hs_cyc[h0+3], 1);
    check("t1_words", n_hs - h0, 4);
    check("t1_done_count", n_done - d0, 1);
    check("t1_rd_count", n_addr - a0, 4);
    for (int i = 0; i < 4; i++) check("t1_rd_addr", addr_log[a0+i], i);
    check("t1_queue_empty", exp_q.size(), 0);
    step();

    // 2: backpressure on word 0x0100
    out_ready = 1'b0;
    d0 = n_done; h0 = n_hs;
    push_words(2);
    pulse_start(2, sc);
    wait_valid("t2");
    a0 = n_addr;
    repeat (5) @(negedge clk);
    #1;
    check("t2_no_rd_while_stalled", n_addr - a0, 0);
    check("t2_valid_held", int'(out_valid), 1);
    check("t2_data_held", int'(out_data), 16'h0100);
    step();
    out_ready = 1'b1;
    wait_done("t2", d0);
    check("t2_words", n_hs - h0, 2);
    check("t2_queue_empty", exp_q.size(), 0);
    step();

    // 3: zero-length request
    d0 = n_done; a0 = n_addr; h0 = n_hs; b0 = n_busy;
    pulse_start(0, sc);
    wait_done("t3", d0);
    check("t3_done_cycle", done_cyc - sc, 1);
    check("t3_busy_cycles", n_busy - b0, 1);
    check("t3_no_rd", n_addr - a0, 0);
    check("t3_no_words", n_hs - h0, 0);
    check("t3_done_count", n_done - d0, 1);
    step();

    // 4: over-long request clamps to DEPTH
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'((i * 16'h1111) ^ 16'hA5A5);
    d0 = n_done; a0 = n_addr; h0 = n_hs;
    push_words(20);
    pulse_start(20, sc);
    wait_done("t4", d0);
    check("t4_rd_count", n_addr - a0, 16);
    for (int i = 0; i < 16; i++) check("t4_rd_addr", addr_log[a0+i], i);
    check("t4_words", n_hs - h0, 16);
    check("t4_done_count", n_done - d0, 1);
    check("t4_queue_empty", exp_q.size(), 0);
    step();

    // 5: second start while busy is ignored
    d0 = n_done; a0 = n_addr; h0 = n_hs;
    push_words(4);
    pulse_start(4, sc);
    wait_hs(h0 + 2);
    step();
    pulse_start(1, dummy);
    wait_done("t5", d0);
    repeat (4) step();
    check("t5_rd_count", n_addr - a0, 4);
    for (int i = 0; i < 4; i++) check("t5_rd_addr", addr_log[a0+i], i);
    check("t5_words", n_hs - h0, 4);
    check("t5_done_count", n_done - d0, 1);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: reset while a word is waiting in SEND
    out_ready = 1'b0;
    push_words(4);
    pulse_start(4, sc);
    wait_valid("t6");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_rd_en", int'(rd_en), 0);
    exp_q.delete();
    step();
    out_ready = 1'b1;
    d0 = n_done; a0 = n_addr; h0 = n_hs;
    push_words(2);
    pulse_start(2, sc);
    wait_done("t6", d0);
    check("t6_rd_count", n_addr - a0, 2);
    check("t6_restart_addr0", addr_log[a0], 0);
    check("t6_restart_addr1", addr_log[a0+1], 1);
    check("t6_words", n_hs - h0, 2);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
